bomb_ctrl: RTL and testbench
============================

BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high, on ports named clk and rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- NUM_ROW, 11, map rows.
- NUM_COL, 19, map columns.
- TILE_PX, 64, tile size in pixels (power of 2).
- SPRITE_W, 32, player sprite width.
- SPRITE_H, 48, player sprite height.
- MAX_SLOTS, 9, physical bomb slots.
- FUSE_TICKS, 3, ticks from placement to detonation.
- EXPLODE_TICKS, 1, ticks an explosion stays active.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- tick, in, 1, single-cycle game-time pulse.
- place_req, in, 1, single-cycle request to drop a bomb.
- player_x, in, 11, map player x.
- player_y, in, 10, map player y.
- max_bombs, in, 4, bomb allowance from the power-up stage.
- bomb_range, in, 4, blast range from the power-up stage.
- place_ack, out, 1, placement accepted (pulse).
- bomb_addr[0:MAX_SLOTS-1], out, ADDR_WIDTH, per-slot tile address.
- bomb_active[0:MAX_SLOTS-1], out, 1, slot holds an unexploded bomb.
- explode_active[0:MAX_SLOTS-1], out, 1, slot is exploding, used by drawcon.
- explode_valid, out, 1, detonation event (pulse).
- explode_addr, out, ADDR_WIDTH, detonation tile.
- explode_range, out, 4, range latched at placement.
- active_count, out, 4, number of non-IDLE slots.
REQ-004 ADDR_WIDTH SHALL be $clog2(NUM_ROW*NUM_COL), and TILE_SHIFT SHALL be $clog2(TILE_PX).

Function
REQ-005 Each slot SHALL hold one of four states: IDLE, FUSE, PENDING, EXPLODE.
REQ-006 The target tile SHALL be computed as follows:
- col = (player_x + SPRITE_W/2) >> TILE_SHIFT.
- row = (player_y + SPRITE_H/2) >> TILE_SHIFT.
- addr = row*NUM_COL + col.
REQ-007 A place_req SHALL be accepted only if all of the following hold:
- row < NUM_ROW and col < NUM_COL.
- active_count < min(max_bombs, MAX_SLOTS).
- No non-IDLE slot holds the same addr.
- At least one slot is IDLE.
REQ-008 On acceptance, the lowest-index IDLE slot SHALL enter FUSE with fuse = FUSE_TICKS, its addr, and range = max(bomb_range, 1) latched; bomb_active and place_ack SHALL be high in cycle N+1 for a request in cycle N.
REQ-009 A rejected place_req SHALL change no state and SHALL leave place_ack low.
REQ-010 In FUSE, each tick SHALL decrement fuse; a tick while fuse==1 SHALL move the slot to PENDING.
REQ-011 A slot placed in the same cycle as a tick SHALL NOT be decremented by that tick.
REQ-012 Each cycle, the lowest-index PENDING slot SHALL be selected and moved to EXPLODE with an explode timer of EXPLODE_TICKS; in the following cycle, explode_valid SHALL be high for exactly one cycle with that slot's explode_addr and explode_range.
REQ-013 At most one explode_valid SHALL be issued per cycle; simultaneous expiries SHALL serialize in ascending slot order on consecutive cycles.
REQ-014 In EXPLODE, explode_active SHALL be high; each tick SHALL decrement the explode timer; a tick at 1 SHALL return the slot to IDLE.
REQ-015 bomb_active SHALL be high in FUSE and PENDING, and explode_active SHALL be high only in EXPLODE.
REQ-016 active_count SHALL be registered and SHALL equal the number of non-IDLE slots after each clock edge; it SHALL never exceed MAX_SLOTS.
REQ-017 A change in max_bombs below active_count SHALL NOT cancel existing bombs; it SHALL only block new placements.
REQ-018 A freed slot SHALL be reusable in the cycle after it returns to IDLE.
REQ-019 Chain detonation by neighbouring explosions SHALL NOT be performed by this block.

Reset
REQ-020 On rst assertion, asynchronously and regardless of in-flight operation, all of the following SHALL hold:
- All slots IDLE with fuse and timers at 0.
- bomb_addr at 0.
- bomb_active, explode_active, place_ack, and explode_valid at 0.
- explode_addr and explode_range at 0.
- active_count at 0.
REQ-021 No pending explosion SHALL be emitted after a reset releases.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Player (0,0), max_bombs=1, bomb_range=2, place_req -> slot0 active with addr 0, place_ack pulse at N+1, active_count=1; a second place_req is rejected.
- After 3 ticks -> explode_valid one cycle with explode_addr=0, explode_range=2; after 1 more tick, slot0 is IDLE and active_count=0.
- max_bombs=3, bombs placed at addrs 20, 21, 22 before any tick, then 3 ticks -> explode_valid on 3 consecutive cycles with addrs 20, 21, 22.
- place_req at an occupied addr, or with player_x=1300 -> no ack and no state change.
- place_req coincident with a tick -> the new bomb explodes after exactly FUSE_TICKS further ticks.
- rst asserted while 2 bombs are in FUSE and 1 is PENDING -> all outputs 0 immediately, and no explode_valid after release.

Source files
------------

// File: rtl/bomb_ctrl.sv
// Bomb slot controller: accepts bomb placements at the player's tile, runs
// each bomb through fuse -> pending -> explode on game ticks, and emits one
// detonation event per cycle in ascending slot order.
module bomb_ctrl #(
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int TILE_PX       = 64,
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 48,
  parameter int MAX_SLOTS     = 9,
  parameter int FUSE_TICKS    = 3,
  parameter int EXPLODE_TICKS = 1,
  localparam int ADDR_WIDTH   = $clog2(NUM_ROW*NUM_COL),
  localparam int TILE_SHIFT   = $clog2(TILE_PX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  place_req,
  input  logic [10:0]           player_x,
  input  logic [9:0]            player_y,
  input  logic [3:0]            max_bombs,
  input  logic [3:0]            bomb_range,
  output logic                  place_ack,
  output logic [ADDR_WIDTH-1:0] bomb_addr      [0:MAX_SLOTS-1],
  output logic                  bomb_active    [0:MAX_SLOTS-1],
  output logic                  explode_active [0:MAX_SLOTS-1],
  output logic                  explode_valid,
  output logic [ADDR_WIDTH-1:0] explode_addr,
  output logic [3:0]            explode_range,
  output logic [3:0]            active_count
);

  localparam int FUSE_W = $clog2(FUSE_TICKS + 1);
  localparam int BOOM_W = $clog2(EXPLODE_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_FUSE, S_PENDING, S_EXPLODE} slot_state_e;

  slot_state_e           state_q [MAX_SLOTS];
  slot_state_e           state_d [MAX_SLOTS];
  logic [FUSE_W-1:0]     fuse_q  [MAX_SLOTS];
  logic [FUSE_W-1:0]     fuse_d  [MAX_SLOTS];
  logic [BOOM_W-1:0]     boom_q  [MAX_SLOTS];
  logic [BOOM_W-1:0]     boom_d  [MAX_SLOTS];
  logic [ADDR_WIDTH-1:0] addr_q  [MAX_SLOTS];
  logic [ADDR_WIDTH-1:0] addr_d  [MAX_SLOTS];
  logic [3:0]            range_q [MAX_SLOTS];
  logic [3:0]            range_d [MAX_SLOTS];
  logic                  bomb_active_q    [MAX_SLOTS];
  logic                  bomb_active_d    [MAX_SLOTS];
  logic                  explode_active_q [MAX_SLOTS];
  logic                  explode_active_d [MAX_SLOTS];

  logic                  place_ack_q, place_ack_d;
  logic                  explode_valid_q, explode_valid_d;
  logic [ADDR_WIDTH-1:0] explode_addr_q, explode_addr_d;
  logic [3:0]            explode_range_q, explode_range_d;
  logic [3:0]            active_count_q, active_count_d;

  logic [11:0]           sum_x;
  logic [10:0]           sum_y;
  logic [31:0]           col_w, row_w, cap_w;
  logic                  tile_ok, dup_hit, free_found, pend_found, accept;
  logic [ADDR_WIDTH-1:0] tile_addr;
  logic [3:0]            range_lat;
  int                    free_idx, pend_idx, cnt;

  // Placement decision, slot selection and per-slot next-state logic.
  always_comb begin
    // Tile under the sprite centre; out-of-map tiles are never accepted.
    sum_x     = {1'b0, player_x} + 12'(SPRITE_W / 2);
    sum_y     = {1'b0, player_y} + 11'(SPRITE_H / 2);
    col_w     = 32'(sum_x >> TILE_SHIFT);
    row_w     = 32'(sum_y >> TILE_SHIFT);
    tile_ok   = (col_w < 32'(NUM_COL)) && (row_w < 32'(NUM_ROW));
    tile_addr = ADDR_WIDTH'(row_w * 32'(NUM_COL) + col_w);
    cap_w     = (32'(max_bombs) < 32'(MAX_SLOTS)) ? 32'(max_bombs) : 32'(MAX_SLOTS);
    range_lat = (bomb_range == 4'd0) ? 4'd1 : bomb_range;

    // Downward scans leave the lowest matching index selected.
    dup_hit    = 1'b0;
    free_found = 1'b0;
    pend_found = 1'b0;
    free_idx   = 0;
    pend_idx   = 0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] != S_IDLE && addr_q[i] == tile_addr) dup_hit = 1'b1;
      if (state_q[i] == S_IDLE) begin
        free_found = 1'b1;
        free_idx   = i;
      end
      if (state_q[i] == S_PENDING) begin
        pend_found = 1'b1;
        pend_idx   = i;
      end
    end

    accept = place_req && tile_ok && !dup_hit && free_found &&
             (32'(active_count_q) < cap_w);

    cnt = 0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      state_d[i] = state_q[i];
      fuse_d[i]  = fuse_q[i];
      boom_d[i]  = boom_q[i];
      addr_d[i]  = addr_q[i];
      range_d[i] = range_q[i];
      case (state_q[i])
        S_IDLE: begin
          // A freshly placed bomb ignores any tick in its placement cycle.
          if (accept && free_idx == i) begin
            state_d[i] = S_FUSE;
            fuse_d[i]  = FUSE_W'(FUSE_TICKS);
            addr_d[i]  = tile_addr;
            range_d[i] = range_lat;
          end
        end
        S_FUSE: begin
          if (tick) begin
            if (fuse_q[i] == FUSE_W'(1)) begin
              state_d[i] = S_PENDING;
              fuse_d[i]  = '0;
            end else begin
              fuse_d[i] = fuse_q[i] - FUSE_W'(1);
            end
          end
        end
        S_PENDING: begin
          // Only one pending slot detonates per cycle; the rest wait.
          if (pend_found && pend_idx == i) begin
            state_d[i] = S_EXPLODE;
            boom_d[i]  = BOOM_W'(EXPLODE_TICKS);
          end
        end
        default: begin
          if (tick) begin
            if (boom_q[i] == BOOM_W'(1)) begin
              state_d[i] = S_IDLE;
              boom_d[i]  = '0;
            end else begin
              boom_d[i] = boom_q[i] - BOOM_W'(1);
            end
          end
        end
      endcase
      bomb_active_d[i]    = (state_d[i] == S_FUSE) || (state_d[i] == S_PENDING);
      explode_active_d[i] = (state_d[i] == S_EXPLODE);
      if (state_d[i] != S_IDLE) cnt = cnt + 1;
    end

    active_count_d  = 4'(cnt);
    place_ack_d     = accept;
    explode_valid_d = pend_found;
    explode_addr_d  = pend_found ? addr_q[pend_idx]  : explode_addr_q;
    explode_range_d = pend_found ? range_q[pend_idx] : explode_range_q;
  end

  // State and registered outputs; reset clears everything including pending detonations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_SLOTS; i++) begin
        state_q[i]          <= S_IDLE;
        fuse_q[i]           <= '0;
        boom_q[i]           <= '0;
        addr_q[i]           <= '0;
        range_q[i]          <= '0;
        bomb_active_q[i]    <= 1'b0;
        explode_active_q[i] <= 1'b0;
      end
      place_ack_q     <= 1'b0;
      explode_valid_q <= 1'b0;
      explode_addr_q  <= '0;
      explode_range_q <= '0;
      active_count_q  <= '0;
    end else begin
      for (int i = 0; i < MAX_SLOTS; i++) begin
        state_q[i]          <= state_d[i];
        fuse_q[i]           <= fuse_d[i];
        boom_q[i]           <= boom_d[i];
        addr_q[i]           <= addr_d[i];
        range_q[i]          <= range_d[i];
        bomb_active_q[i]    <= bomb_active_d[i];
        explode_active_q[i] <= explode_active_d[i];
      end
      place_ack_q     <= place_ack_d;
      explode_valid_q <= explode_valid_d;
      explode_addr_q  <= explode_addr_d;
      explode_range_q <= explode_range_d;
      active_count_q  <= active_count_d;
    end
  end

  // Per-slot output ports.
  for (genvar gi = 0; gi < MAX_SLOTS; gi++) begin : g_slot_out
    assign bomb_addr[gi]      = addr_q[gi];
    assign bomb_active[gi]    = bomb_active_q[gi];
    assign explode_active[gi] = explode_active_q[gi];
  end

  assign place_ack     = place_ack_q;
  assign explode_valid = explode_valid_q;
  assign explode_addr  = explode_addr_q;
  assign explode_range = explode_range_q;
  assign active_count  = active_count_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Directed bench for bomb_ctrl: placement, fuse/explode timing, serialized
// detonations, rejections and mid-flight reset.
module tb_bomb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        place_req = 1'b0;
  logic [10:0] player_x = '0;
  logic [9:0]  player_y = '0;
  logic [3:0]  max_bombs = '0;
  logic [3:0]  bomb_range = '0;
  logic        place_ack;
  logic [7:0]  bomb_addr      [0:8];
  logic        bomb_active    [0:8];
  logic        explode_active [0:8];
  logic        explode_valid;
  logic [7:0]  explode_addr;
  logic [3:0]  explode_range;
  logic [3:0]  active_count;

  int n_checks = 0;
  int n_pass   = 0;

  bomb_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .place_req      (place_req),
    .player_x       (player_x),
    .player_y       (player_y),
    .max_bombs      (max_bombs),
    .bomb_range     (bomb_range),
    .place_ack      (place_ack),
    .bomb_addr      (bomb_addr),
    .bomb_active    (bomb_active),
    .explode_active (explode_active),
    .explode_valid  (explode_valid),
    .explode_addr   (explode_addr),
    .explode_range  (explode_range),
    .active_count   (active_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input int x, input int y, input logic with_tick);
    player_x  = 11'(x);
    player_y  = 10'(y);
    place_req = 1'b1;
    tick      = with_tick;
    step();
    place_req = 1'b0;
    tick      = 1'b0;
    $display("place x=%0d y=%0d tick=%0d ack=%0d count=%0d", x, y, with_tick, place_ack, active_count);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    $display("tick count=%0d xv=%0d xaddr=%0d", active_count, explode_valid, explode_addr);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ack", place_ack, 0);
    check("rst_count", active_count, 0);
    check("rst_xv", explode_valid, 0);
    check("rst_bact0", bomb_active[0], 0);
    step();
    rst = 1'b0;
    step();

    // Single bomb at (0,0)
    max_bombs  = 4'd1;
    bomb_range = 4'd2;
    place(0, 0, 1'b0);
    check("s1_ack", place_ack, 1);
    check("s1_bact0", bomb_active[0], 1);
    check("s1_addr0", bomb_addr[0], 0);
    check("s1_count", active_count, 1);
    step();
    check("s1_ack_pulse", place_ack, 0);
    place(200, 0, 1'b0);
    check("s1_rej_ack", place_ack, 0);
    check("s1_rej_count", active_count, 1);
    check("s1_rej_bact1", bomb_active[1], 0);

    do_tick();
    do_tick();
    do_tick();
    check("s1_pend_xv", explode_valid, 0);
    check("s1_pend_bact", bomb_active[0], 1);
    step();
    check("s1_xv", explode_valid, 1);
    check("s1_xaddr", explode_addr, 0);
    check("s1_xrange", explode_range, 2);
    check("s1_xact0", explode_active[0], 1);
    check("s1_bact_off", bomb_active[0], 0);
    step();
    check("s1_xv_pulse", explode_valid, 0);
    do_tick();
    check("s1_idle_count", active_count, 0);
    check("s1_idle_xact", explode_active[0], 0);

    // Three bombs, serialized detonations
    max_bombs  = 4'd3;
    bomb_range = 4'd5;
    place(48, 40, 1'b0);
    bomb_range = 4'd0;
    place(112, 40, 1'b0);
    bomb_range = 4'd15;
    place(176, 40, 1'b0);
    check("s3_count", active_count, 3);
    check("s3_addr1", bomb_addr[1], 21);
    check("s3_addr2", bomb_addr[2], 22);
    place(240, 40, 1'b0);
    check("s3_cap_ack", place_ack, 0);
    check("s3_cap_count", active_count, 3);
    max_bombs = 4'd1;
    step();
    check("s3_shrink_count", active_count, 3);
    check("s3_shrink_bact2", bomb_active[2], 1);

    // Rejections: occupied tile and off-map x
    max_bombs = 4'd15;
    place(48, 40, 1'b0);
    check("s4_dup_ack", place_ack, 0);
    check("s4_dup_count", active_count, 3);
    place(1300, 40, 1'b0);
    check("s4_offmap_ack", place_ack, 0);
    check("s4_offmap_bact3", bomb_active[3], 0);
    max_bombs = 4'd3;

    do_tick();
    do_tick();
    do_tick();
    check("s3_pend_xv", explode_valid, 0);
    step();
    check("s3_xv0", explode_valid, 1);
    check("s3_xaddr0", explode_addr, 20);
    check("s3_xrange0", explode_range, 5);
    step();
    check("s3_xv1", explode_valid, 1);
    check("s3_xaddr1", explode_addr, 21);
    check("s3_xrange1", explode_range, 1);
    step();
    check("s3_xv2", explode_valid, 1);
    check("s3_xaddr2", explode_addr, 22);
    check("s3_xrange2", explode_range, 15);
    step();
    check("s3_xv_end", explode_valid, 0);
    do_tick();
    check("s3_idle_count", active_count, 0);

    // Placement coincident with a tick
    bomb_range = 4'd3;
    place(0, 0, 1'b1);
    check("s5_ack", place_ack, 1);
    do_tick();
    do_tick();
    step();
    check("s5_early_xv", explode_valid, 0);
    check("s5_still_fuse", bomb_active[0], 1);
    do_tick();
    step();
    check("s5_xv", explode_valid, 1);
    check("s5_xaddr", explode_addr, 0);
    do_tick();
    check("s5_idle_count", active_count, 0);

    // Reset with two bombs in FUSE and one PENDING
    place(48, 40, 1'b0);
    do_tick();
    do_tick();
    place(112, 40, 1'b0);
    place(176, 40, 1'b0);
    do_tick();
    check("s6_pre_count", active_count, 3);
    check("s6_pre_xv", explode_valid, 0);
    rst = 1'b1;
    #1;
    check("s6_rst_count", active_count, 0);
    check("s6_rst_bact0", bomb_active[0], 0);
    check("s6_rst_bact1", bomb_active[1], 0);
    check("s6_rst_addr1", bomb_addr[1], 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("s6_post_xv", explode_valid, 0);
    end
    check("s6_post_count", active_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
